id_bcd_sequencer: RTL and testbench

//  Sequencer for the tag-ID decimal path. Captures a 45-bit tag frame from the

---
 rtl/id_bcd_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_id_bcd_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_bcd_sequencer.sv
// id_bcd_sequencer: tag-ID decimal path.
// Captures a 45-bit tag frame, extracts the 16-bit ID (frame[16:1]) and
// converts it to four BCD digits with a 16-step shift/add-3 loop. The result
// is held and time-multiplexed onto a 4-digit active-low 7-seg anode scan.
// Optional feature macro: ID_PARITY_EN (even parity over frame[16:0]).
module id_bcd_sequencer #(
    parameter int SCAN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [44:0] frame,
    output logic        busy,
    output logic        id_valid,
    output logic [15:0] iddecimal4,
    output logic        overflow,
    output logic        drop,
    output logic        err,
    output logic [3:0]  an,
    output logic [3:0]  bcd_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  step_q, step_d;
    logic        pend_valid_q, pend_valid_d;
    logic [15:0] pend_id_q, pend_id_d;
    logic [15:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        id_valid_q, id_valid_d;
    logic        drop_q, drop_d;

    logic [SCAN_W-1:0] cnt_q;
    logic [3:0]        an_q;
    logic [3:0]        bcd_out_q;

    logic [15:0] frame_id;
    logic        frame_ok;
    logic        accept;
    logic [19:0] bcd_adj;

    assign frame_id = frame[16:1];

`ifdef ID_PARITY_EN
    logic err_q, err_d;
    // Even parity across ID and parity bit.
    assign frame_ok = ~(^frame[16:0]);
    assign err      = err_q;
    logic unused_frame_bits;
    assign unused_frame_bits = ^frame[44:17];
`else
    assign frame_ok = 1'b1;
    assign err      = 1'b0;
    logic unused_frame_bits;
    assign unused_frame_bits = ^{frame[44:17], frame[0]};
`endif

    assign accept = frame_valid & frame_ok;

    // Add-3 correction: every BCD nibble >= 5 is bumped before the shift.
    function automatic logic [19:0] add3(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_q);

    // Next-state, datapath and pending-slot logic for the conversion FSM.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        step_d       = step_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        result_d     = result_q;
        overflow_d   = overflow_q;
        id_valid_d   = 1'b0;
        drop_d       = 1'b0;
`ifdef ID_PARITY_EN
        err_d        = frame_valid & ~frame_ok;
`endif

        // While busy, accepted frames park in the 1-deep pending slot.
        if (state_q != IDLE && accept) begin
            pend_valid_d = 1'b1;
            pend_id_d    = frame_id;
            drop_d       = pend_valid_q;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    bin_d   = frame_id;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = '0;
                step_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d  = {bcd_adj[18:0], bin_q[15]};
                bin_d  = {bin_q[14:0], 1'b0};
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bcd_q[19:16] != 4'd0) begin
                    result_d   = 16'h9999;
                    overflow_d = 1'b1;
                end else begin
                    result_d   = bcd_q[15:0];
                    overflow_d = 1'b0;
                end
                id_valid_d = 1'b1;
                // A frame arriving now wins over the slot and is taken
                // straight into the next LOAD without a bubble.
                if (accept || pend_valid_q) begin
                    bin_d        = accept ? frame_id : pend_id_q;
                    pend_valid_d = 1'b0;
                    state_d      = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            id_valid_q   <= 1'b0;
            drop_q       <= 1'b0;
`ifdef ID_PARITY_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            id_valid_q   <= id_valid_d;
            drop_q       <= drop_d;
`ifdef ID_PARITY_EN
            err_q        <= err_d;
`endif
        end
    end

    // Conversion datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are left unreset; they are always written
        // (IDLE capture, LOAD clear) before any value of theirs is used.
        bin_q     <= bin_d;
        bcd_q     <= bcd_d;
        step_q    <= step_d;
        pend_id_q <= pend_id_d;
    end

    // Free-running scan counter with registered anode/digit pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            an_q      <= 4'b1111;
            bcd_out_q <= 4'd0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            unique case (cnt_q[SCAN_W-1 -: 2])
                2'd0: begin an_q <= 4'b1110; bcd_out_q <= result_q[3:0];   end
                2'd1: begin an_q <= 4'b1101; bcd_out_q <= result_q[7:4];   end
                2'd2: begin an_q <= 4'b1011; bcd_out_q <= result_q[11:8];  end
                default: begin an_q <= 4'b0111; bcd_out_q <= result_q[15:12]; end
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign id_valid   = id_valid_q;
    assign iddecimal4 = result_q;
    assign overflow   = overflow_q;
    assign drop       = drop_q;
    assign an         = an_q;
    assign bcd_out    = bcd_out_q;

endmodule

// File: tb/tb_id_bcd_sequencer.sv
// Self-checking bench for id_bcd_sequencer: vector table through a result
// scoreboard, plus hand-written latency, pending/drop, reset-abort, parity
// and display-scan sequences.
module tb_id_bcd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic [44:0] frame;
    logic        busy;
    logic        id_valid;
    logic [15:0] iddecimal4;
    logic        overflow;
    logic        drop;
    logic        err;
    logic [3:0]  an;
    logic [3:0]  bcd_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] id;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    id_bcd_sequencer #(.SCAN_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame       (frame),
        .busy        (busy),
        .id_valid    (id_valid),
        .iddecimal4  (iddecimal4),
        .overflow    (overflow),
        .drop        (drop),
        .err         (err),
        .an          (an),
        .bcd_out     (bcd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Build a frame; good=1 gives even parity over frame[16:0].
    function automatic logic [44:0] mk_frame(input logic [15:0] id, input logic good);
        logic p;
        logic [27:0] hi;
        p  = ^id;
        hi = 28'($urandom);
        return {hi, id, good ? p : ~p};
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] b, input logic o);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        return e;
    endfunction

    // Scoreboard: every id_valid pops one expected result.
    always @(negedge clk) begin
        if (id_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_id_valid: got iddecimal4=%h, expected no result (t=%0t)",
                         iddecimal4, $time);
            end else begin
                mon_e = sb.pop_front();
                check("id_result", {15'd0, overflow, iddecimal4}, {15'd0, mon_e.ovf, mon_e.bcd});
            end
        end
    end

    // Wait (bounded) until all expected results have come out and FSM is idle.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check(name, {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
        sb.delete();
    endtask

    // One conversion with exact cycle-by-cycle busy/id_valid timing.
    // Called at a negedge; the strobe is sampled by the next edge (edge 0).
    task automatic run_timed(input string name, input logic [15:0] id,
                             input logic [15:0] exp_b, input logic exp_o);
        frame_valid = 1'b1;
        frame       = mk_frame(id, 1'b1);
        sb.push_back(mk_exp(exp_b, exp_o));
        for (int n = 0; n <= 18; n++) begin
            @(posedge clk);
            #1 frame_valid = 1'b0;
            @(negedge clk);
            check({name, "_busy"}, {31'd0, busy}, {31'd0, (n <= 17)});
            check({name, "_id_valid"}, {31'd0, id_valid}, {31'd0, (n == 18)});
        end
    endtask

    vec_t vecs[12];
    logic [3:0] scan_an[4];
    logic [3:0] scan_dg[4];
    logic [3:0] prev_an;
    logic       found;

    initial begin
        vecs[0]  = '{16'h10A0, 16'h4256, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h9999, 1'b1};
        vecs[2]  = '{16'd9999, 16'h9999, 1'b0};
        vecs[3]  = '{16'd0,    16'h0000, 1'b0};
        vecs[4]  = '{16'd1,    16'h0001, 1'b0};
        vecs[5]  = '{16'd10000,16'h9999, 1'b1};
        vecs[6]  = '{16'd9,    16'h0009, 1'b0};
        vecs[7]  = '{16'd31,   16'h0031, 1'b0};
        vecs[8]  = '{16'd1234, 16'h1234, 1'b0};
        vecs[9]  = '{16'd777,  16'h0777, 1'b0};
        vecs[10] = '{16'd1000, 16'h1000, 1'b0};
        vecs[11] = '{16'd5000, 16'h5000, 1'b0};
        scan_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_dg = '{4'd6, 4'd5, 4'd2, 4'd4};

        // ---- reset state ----
        reset       = 1'b1;
        frame_valid = 1'b0;
        frame       = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_result",   {16'd0, iddecimal4}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop",     {31'd0, drop},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check("rst_an",       {28'd0, an},       {28'd0, 4'b1111});
        reset = 1'b0;
        @(negedge clk);
        check("scan_start_an",  {28'd0, an},      {28'd0, 4'b1110});
        check("scan_start_bcd", {28'd0, bcd_out}, 32'd0);

        // ---- basic latency: ID 4256 ----
        run_timed("lat4256", 16'h10A0, 16'h4256, 1'b0);
        wait_idle("lat4256_drain");

        // ---- display scan on result 4256 (SCAN_W=4) ----
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev_an == 4'b0111) begin
                found = 1'b1;
                break;
            end
            prev_an = an;
        end
        check("scan_sync", {31'd0, found}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            check("scan_an",  {28'd0, an},      {28'd0, scan_an[i/4]});
            check("scan_bcd", {28'd0, bcd_out}, {28'd0, scan_dg[i/4]});
        end

        // ---- vector table through the scoreboard ----
        foreach (vecs[k]) begin
            frame_valid = 1'b1;
            frame       = mk_frame(vecs[k].id, 1'b1);
            sb.push_back(mk_exp(vecs[k].exp_bcd, vecs[k].exp_ovf));
            @(posedge clk);
            #1 frame_valid = 1'b0;
            @(negedge clk);
            wait_idle("vec_drain");
        end

        // ---- pending overwrite: 1234 @0, 9 @5, 777 @7 -> drop after edge 7 ----
        sb.push_back(mk_exp(16'h1234, 1'b0));
        sb.push_back(mk_exp(16'h0777, 1'b0));
        for (int n = 0; n <= 12; n++) begin
            frame_valid = (n == 0 || n == 5 || n == 7);
            frame = mk_frame((n == 0) ? 16'd1234 : (n == 5) ? 16'd9 : 16'd777, 1'b1);
            @(posedge clk);
            #1 frame_valid = 1'b0;
            @(negedge clk);
            check("pend_drop", {31'd0, drop}, {31'd0, (n == 7)});
        end
        wait_idle("pend_drain");

        // ---- frame strobed in DONE (edge 18): taken with no drop, no bubble ----
        sb.push_back(mk_exp(16'h0042, 1'b0));
        sb.push_back(mk_exp(16'h8191, 1'b0));
        for (int n = 0; n <= 20; n++) begin
            frame_valid = (n == 0 || n == 18);
            frame = mk_frame((n == 0) ? 16'd42 : 16'd8191, 1'b1);
            @(posedge clk);
            #1 frame_valid = 1'b0;
            @(negedge clk);
            check("done_drop", {31'd0, drop}, 32'd0);
            if (n >= 17) check("done_busy", {31'd0, busy}, 32'd1);
        end
        wait_idle("done_drain");

        // ---- reset mid-conversion aborts, then fresh ID 31 ----
        for (int n = 0; n <= 10; n++) begin
            frame_valid = (n == 0);
            frame       = mk_frame(16'h10A0, 1'b1);
            reset       = (n == 10);
            @(posedge clk);
            #1 frame_valid = 1'b0;
            reset = 1'b0;
            @(negedge clk);
        end
        check("abort_busy",   {31'd0, busy},       32'd0);
        check("abort_result", {16'd0, iddecimal4}, 32'd0);
        check("abort_ovf",    {31'd0, overflow},   32'd0);
        check("abort_an",     {28'd0, an},         {28'd0, 4'b1111});
        repeat (25) @(negedge clk);
        run_timed("fresh31", 16'd31, 16'h0031, 1'b0);
        wait_idle("fresh31_drain");

        // ---- parity: ID 10A0 with frame[0]=0 (odd parity) ----
        frame_valid = 1'b1;
        frame       = mk_frame(16'h10A0, 1'b0);
`ifndef ID_PARITY_EN
        sb.push_back(mk_exp(16'h4256, 1'b0));
`endif
        @(posedge clk);
        #1 frame_valid = 1'b0;
        @(negedge clk);
`ifdef ID_PARITY_EN
        check("par_err",  {31'd0, err},  32'd1);
        check("par_busy", {31'd0, busy}, 32'd0);
        repeat (25) @(negedge clk);
        check("par_hold", {16'd0, iddecimal4}, 32'h0031);
`else
        check("par_err",  {31'd0, err},  32'd0);
        check("par_busy", {31'd0, busy}, 32'd1);
`endif
        wait_idle("par_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
